// File: rtl/axiom_pio_bank.sv
// Multi-channel parallel output bank with an Avalon-MM slave port. Writes go to
// shadow registers; a commit copies every shadow into the active outputs at once.
module axiom_pio_bank #(
  parameter int          NUM_CH      = 4,
  parameter int          WIDTH       = 32,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter bit          AUTO_COMMIT = 1'b0,
  localparam int         CH_BITS     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int         AW          = CH_BITS + 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [AW-1:0]           address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [NUM_CH*WIDTH-1:0] out_port,
  output logic                    out_valid,
  input  logic                    out_ack
);

  localparam logic [WIDTH-1:0] RST_V = RESET_VALUE[WIDTH-1:0];

  typedef enum logic [1:0] {
    OP_DATA = 2'd0,
    OP_SET  = 2'd1,
    OP_CLR  = 2'd2,
    OP_CTRL = 2'd3
  } op_e;

  op_e                op;
  logic [CH_BITS-1:0] ch;
  logic               ch_ok;
  logic               wr;
  logic               shadow_wr;
  logic               ctrl_wr;
  logic               commit;
  logic               ovr_set;
  logic               ovr_clr;
  logic               overrun;
  logic [WIDTH-1:0]   wr_data;
  logic [WIDTH-1:0]   shadow [NUM_CH];
  logic [WIDTH-1:0]   active [NUM_CH];
  logic [WIDTH-1:0]   s_next [NUM_CH];
  logic [WIDTH-1:0]   rd_s;
  logic [WIDTH-1:0]   rd_a;
  logic               unused_wdata;

  assign op           = op_e'(address[1:0]);
  assign ch           = address[AW-1:2];
  assign ch_ok        = int'(ch) < NUM_CH;
  assign wr           = chipselect & ~write_n;
  assign wr_data      = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  // The control op ignores the channel field, so it acts even on unmapped channels.
  assign ctrl_wr   = wr && (op == OP_CTRL);
  assign shadow_wr = wr && (op != OP_CTRL) && ch_ok;
  assign commit    = (ctrl_wr && writedata[0]) || (AUTO_COMMIT && shadow_wr);
  assign ovr_clr   = ctrl_wr && writedata[1];
  assign ovr_set   = commit && out_valid && !out_ack;

  // Active registers load from s_next so an auto-commit captures the just-modified shadow.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      s_next[k] = shadow[k];
      if (shadow_wr && (ch == CH_BITS'(k))) begin
        case (op)
          OP_DATA: s_next[k] = wr_data;
          OP_SET:  s_next[k] = shadow[k] | wr_data;
          OP_CLR:  s_next[k] = shadow[k] & ~wr_data;
          default: s_next[k] = shadow[k];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the register arrays are reset too; they drive pins, so they must never power up as X.
      for (int k = 0; k < NUM_CH; k++) begin
        shadow[k] <= RST_V;
        active[k] <= RST_V;
      end
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      for (int k = 0; k < NUM_CH; k++) begin
        shadow[k] <= s_next[k];
        if (commit) active[k] <= s_next[k];
      end
      if (commit)       out_valid <= 1'b1;
      else if (out_ack) out_valid <= 1'b0;
      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  always_comb begin
    rd_s = '0;
    rd_a = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch == CH_BITS'(k)) begin
        rd_s = shadow[k];
        rd_a = active[k];
      end
    end
  end

  always_comb begin
    readdata = '0;
    if (ch_ok) begin
      case (op)
        OP_DATA: readdata = 32'(rd_s);
        OP_SET:  readdata = {30'b0, overrun, out_valid};
        OP_CLR:  readdata = '0;
        OP_CTRL: readdata = 32'(rd_a);
        default: readdata = '0;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_out
    assign out_port[k*WIDTH +: WIDTH] = active[k];
  end

endmodule

// File: doc/axiom_pio_bank.md
AXIOM_PIO_BANK -- requirements
Module: axiom_pio_bank

Interface
REQ-001 Parameter NUM_CH, default 4: number of output channels, range 1..16.
REQ-002 Parameter WIDTH, default 32: bits per channel, range 1..32.
REQ-003 Parameter RESET_VALUE, default 0: reset value of every channel, truncated to WIDTH bits.
REQ-004 Parameter AUTO_COMMIT, default 0: 1 = every shadow write also commits.
REQ-005 Local CH_BITS = max(1, clog2(NUM_CH)); local AW = CH_BITS+2.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 address  in  AW  {channel index, op[1:0]}.
REQ-009 chipselect  in  1  Avalon-MM slave select.
REQ-010 write_n  in  1  active-low write strobe; write = chipselect & ~write_n.
REQ-011 writedata  in  32  write data; bits above WIDTH ignored.
REQ-012 readdata  out  32  combinational read data, zero-padded above WIDTH.
REQ-013 out_port  out  NUM_CH*WIDTH  active registers; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-014 out_valid  out  1  new active set pending for the consumer.
REQ-015 out_ack  in  1  consumer has taken the active set.

Function
REQ-016 Each channel SHALL hold a shadow register S[k] and an active register A[k], each WIDTH bits.
REQ-017 Op 0, write: S[ch] <= writedata; op 0, read: returns S[ch].
REQ-018 Op 1, write: S[ch] <= S[ch] | writedata (bit set); op 1, read: returns {30'b0, overrun, out_valid}.
REQ-019 Op 2, write: S[ch] <= S[ch] & ~writedata (bit clear); op 2, read: returns 0.
REQ-020 Op 3, write: writedata[0]=1 requests a commit; writedata[1]=1 clears overrun; the channel field is ignored.
REQ-021 Op 3, read: returns A[ch].
REQ-022 Channel index >= NUM_CH: writes have no effect; reads return 0.
REQ-023 Commit: on the cycle after the request edge, every A[k] holds the S[k] values from that edge, all channels atomically, and out_valid = 1.
REQ-024 AUTO_COMMIT=1: every op 0/1/2 write also commits; A[ch] reflects the modified S[ch] one cycle after the write edge.
REQ-025 Handshake: out_valid stays 1 until a rising edge with out_ack=1 and no commit, then goes to 0; out_ack with out_valid=0 is ignored.
REQ-026 Commit while out_valid=1 and out_ack=0: A is overwritten, out_valid stays 1, and the sticky overrun bit is set.
REQ-027 Commit and out_ack on the same edge: A is updated, out_valid stays 1, and overrun is not set.
REQ-028 Overrun set and clear on the same edge (op 3 write with bits [1:0] = 11 while pending): the set wins.
REQ-029 readdata SHALL be a combinational decode of address with no read strobe; there are no side effects on read.
REQ-030 out_port SHALL change only on commit or reset, never on shadow writes when AUTO_COMMIT=0.

Reset
REQ-031 While reset=1, asynchronously: S[k] = A[k] = RESET_VALUE, out_valid = 0, overrun = 0.
REQ-032 Reset asserted mid-handshake discards the pending set; after release, out_valid = 0 and out_port = RESET_VALUE on all channels.
REQ-033 The first write is accepted on the first rising edge after reset deasserts.

Verification
REQ-034 Defaults, write 0xA5 to ch1 op 0 -> out_port unchanged (all 0); after an op 3 write of 0x1, out_port[63:32] = 0xA5 and out_valid = 1 next cycle; a later out_ack=1 edge -> out_valid = 0.
REQ-035 S[0] = 0xF0, op 1 write 0x0F, op 2 write 0x81, commit -> A[0] = 0x7E; op 3 read of ch0 returns 0x0000007E.
REQ-036 Commit twice with no ack -> op 1 read returns 0x3; op 3 write of 0x2 -> op 1 read returns 0x1.
REQ-037 Commit on the same edge as out_ack=1 while pending -> out_valid stays 1, op 1 read returns 0x1.
REQ-038 AUTO_COMMIT=1, WIDTH=8, NUM_CH=3: write 0x1FF to ch2 op 0 -> out_port[23:16] = 0xFF one cycle later; write to ch3 -> no change, read of ch3 = 0.
REQ-039 Reset pulse while out_valid=1, RESET_VALUE=0x5 -> out_valid = 0 immediately, every channel = 0x5, overrun = 0.
